// File: rtl/e_mdu_pkg.sv
// Shared MDU operation codes and FSM encodings; the D-stage controller
// imports the same constants when it generates D_MDU_Ctr.
package cpu_defs;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational mult/div datapath producing the {HI, LO} result that e_mdu
// holds pending until the modelled latency expires.
module mdu_calc
  import cpu_defs::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o
);

  logic        sgn_div;
  logic [31:0] abs_rs, abs_rt, dvsr, quo, rem;
  logic [63:0] ext_rs, ext_rt;

  // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps to 0x80000000 naturally.
  always_comb begin
    sgn_div = (op_i == MDU_DIV);
    abs_rs  = (sgn_div && rs_i[31]) ? -rs_i : rs_i;
    abs_rt  = (sgn_div && rt_i[31]) ? -rt_i : rt_i;
    dvsr    = (rt_i == 32'd0) ? 32'd1 : abs_rt;
    quo     = abs_rs / dvsr;
    rem     = abs_rs % dvsr;
    if (sgn_div && (rs_i[31] ^ rt_i[31])) quo = -quo;
    if (sgn_div && rs_i[31])              rem = -rem;

    ext_rs = (op_i == MDU_MULT) ? {{32{rs_i[31]}}, rs_i} : {32'd0, rs_i};
    ext_rt = (op_i == MDU_MULT) ? {{32{rt_i[31]}}, rt_i} : {32'd0, rt_i};

    res_o = {hi_i, lo_i};
    case (op_i)
      MDU_MULT, MDU_MULTU: res_o = ext_rs * ext_rt;
      MDU_DIV, MDU_DIVU:   if (rt_i != 32'd0) res_o = {rem, quo};
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// down-counter and reports busy to the hazard unit.
module e_mdu
  import cpu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  mdu_ctr,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic             busy_q;
  logic [63:0]      pend_d;

  mdu_calc u_calc (
    .op_i  (mdu_ctr),
    .rs_i  (rs),
    .rt_i  (rt),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .res_o (pend_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (!Req) begin
            if (start && is_muldiv(mdu_ctr)) begin
              pend_hi_q <= pend_d[63:32];
              pend_lo_q <= pend_d[31:0];
              cnt_q     <= is_mul(mdu_ctr) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              busy_q    <= 1'b1;
              state_q   <= MDU_RUN;
            end else if (mdu_ctr == MDU_MTHI) begin
              hi_q <= rs;
            end else if (mdu_ctr == MDU_MTLO) begin
              lo_q <= rs;
            end
          end
        end
        MDU_RUN: begin
          // Req here belongs to a younger instruction; the running op still retires.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            busy_q  <= 1'b0;
            state_q <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  always_comb begin
    mdu_out = 32'd0;
    case (mdu_ctr)
      MDU_MFHI: mdu_out = hi_q;
      MDU_MFLO: mdu_out = lo_q;
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a monitor scores each completed mult/div against
// a queue of hand-computed {HI, LO, busy length} entries.
module tb_e_mdu;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset, Req, start;
  logic [3:0]  mdu_ctr;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo, mdu_out;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Req(Req), .start(start), .mdu_ctr(mdu_ctr),
    .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a falling busy marks a retired op; score HI/LO and busy length.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else if (busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt != 0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_completion: hi %h lo %h with empty queue", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_hi", hi, e.hi);
        chk("done_lo", lo, e.lo);
        chk("busy_len", 32'(busy_cnt), 32'(e.cyc));
      end
      busy_cnt = 0;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    start   = is_muldiv(op);
    mdu_ctr = op;
    rs      = a;
    rt      = b;
    Req     = req;
    @(posedge clk); #1;
    start   = 1'b0;
    mdu_ctr = MDU_NONE;
    Req     = 1'b0;
  endtask

  task automatic expect_op(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy %b after %0d cycles, required 0", busy, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; start = 1'b0; mdu_ctr = MDU_NONE; rs = '0; rt = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    mdu_ctr = MDU_MFHI; #1;
    chk("rst_mfhi", mdu_out, 32'd0);
    mdu_ctr = MDU_NONE;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_busy_rise", {31'd0, busy}, 32'd1);
    wait_idle();

    expect_op(32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();

    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();

    issue(MDU_MTHI, 32'h11, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'h22, 32'd0, 1'b0);
    chk("mthi_11", hi, 32'h11);
    chk("mtlo_22", lo, 32'h22);

    expect_op(32'h11, 32'h22, 10);
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle();

    expect_op(32'h0, 32'h8000_0000, 10);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();

    expect_op(32'h1, 32'h7FFF_FFFC, 10);
    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();

    issue(MDU_MULT, 32'd5, 32'd6, 1'b1);
    chk("req_launch_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("req_launch_busy2", {31'd0, busy}, 32'd0);
    chk("req_launch_hi", hi, 32'h1);
    chk("req_launch_lo", lo, 32'h7FFF_FFFC);

    // div 7 / -2 with a Req pulse and a stray start/mthi while running
    expect_op(32'h1, 32'hFFFF_FFFD, 10);
    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    @(posedge clk); #1;
    Req = 1'b1;
    @(posedge clk); #1;
    Req = 1'b0;
    issue(MDU_MULT, 32'd2, 32'd2, 1'b0);
    issue(MDU_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0);
    chk("run_hi_held", hi, 32'h1);
    wait_idle();

    issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    mdu_ctr = MDU_MFHI; #1;
    chk("mfhi_out", mdu_out, 32'hDEAD_BEEF);
    mdu_ctr = MDU_MFLO; #1;
    chk("mflo_out", mdu_out, 32'hFFFF_FFFD);
    mdu_ctr = MDU_NONE; #1;
    chk("none_out", mdu_out, 32'd0);
    issue(MDU_MTLO, 32'h1234_5678, 32'd0, 1'b1);
    chk("mtlo_req_lo", lo, 32'hFFFF_FFFD);

    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    expect_op(32'd0, 32'd12, 5);
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    wait_idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It sits directly downstream of the D/E pipeline register and consumes E_MDU_Ctr, E_start, E_RD1 and E_RD2 (after forwarding muxes), plus the global exception request Req.
- Owns the architectural HI/LO registers and models the multi-cycle latency of mult/div.
- Drives busy to the hazard unit and supplies the mfhi/mflo read value to the E-stage result mux.

Parameters:
MULT_CYCLES, 5, cycles busy stays high after a mult/multu launch (>=1)
DIV_CYCLES, 10, cycles busy stays high after a div/divu launch (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
Req  in  1  exception/interrupt request; the instruction currently in E is being flushed
start  in  1  E_start; E-stage instruction is mult/multu/div/divu
mdu_ctr  in  4  E_MDU_Ctr operation code (see package)
rs  in  32  forwarded rs operand
rt  in  32  forwarded rt operand
busy  out  1  unit running a mult/div
hi  out  32  current HI
lo  out  32  current LO
mdu_out  out  32  mfhi→hi, mflo→lo, otherwise 0

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, busy=0, counter=0, HI=0, LO=0, pending result regs=0. Any in-flight op is dropped.
- State machine has two states, IDLE and RUN.
- IDLE → RUN transition:
  - Condition: start=1 && Req=0 && mdu_ctr ∈ {MULT, MULTU, DIV, DIVU}.
  - At that edge: compute the 64-bit result from rs/rt into pending_hi/pending_lo; load counter with MULT_CYCLES or DIV_CYCLES; busy←1.
- RUN:
  - Each edge: counter←counter-1.
  - When counter==1 at an edge: HI←pending_hi, LO←pending_lo, busy←0, state←IDLE.
  - Result: busy is high exactly N cycles, and HI/LO hold the new values from edge t0+N, where t0 is the launch edge.
- busy is purely registered. The hazard unit stalls D on (start|busy) when the D instruction uses the MDU; that gating lives outside this block.
- start asserted while busy=1: ignored (the stall rule prevents it); no relaunch, no HI/LO change.
- Req=1 in the launch cycle: no launch; HI/LO unchanged; remain IDLE.
- Req during RUN: the op was launched by an earlier, already-committed instruction, so it completes normally.
- mthi/mtlo:
  - In IDLE with Req=0: HI←rs or LO←rs at the edge.
  - With Req=1: no write.
  - Never issued while busy (stall guaranteed); if issued anyway, ignored.
- Arithmetic:
  - mult: signed 32×32→64, HI=[63:32], LO=[31:0]. multu: unsigned equivalent.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (rt==0): pending = current HI/LO (values unchanged); busy still runs DIV_CYCLES.
- mdu_out is combinational from the current HI/LO and mdu_ctr. During RUN it returns the old values, but mfhi/mflo is stalled by the hazard unit in that case.
- Codes not listed (incl. NONE): no state effect; mdu_out=0.

Decomposition:
- Shared package (cpu_defs): MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MFHI=7, MDU_MFLO=8; state encodings MDU_IDLE/MDU_RUN.
- The same constants are used by the D-stage controller that generates D_MDU_Ctr.
- One sub-module is natural: mdu_calc, a purely combinational block taking op, rs, rt, HI, LO and returning the 64-bit pending result, including the signed/unsigned and divide-by-zero rules. Counter/FSM/HI-LO registers stay in e_mdu.

Test Plan:
- mult rs=0xFFFFFFFE (−2), rt=3, start at edge t0 → busy=1 for 5 cycles; at t0+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div rs=−7 (0xFFFFFFF9), rt=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with HI=0x11, LO=0x22 → after 10 cycles HI=0x11, LO=0x22 unchanged.
- Req=1 together with start/mult → busy stays 0, HI/LO unchanged. Req pulse at cycle 3 of a running div → completes at cycle 10 with correct values.
- mthi rs=0xDEADBEEF, then mflo/mfhi → hi=0xDEADBEEF, mdu_out=0xDEADBEEF for MFHI. mtlo with Req=1 → LO unchanged.
- reset asserted asynchronously mid-RUN (cycle 2 of mult) → busy, HI, LO drop to 0 immediately without a clock edge; after release the unit is IDLE and accepts a new start.
